mem_bus_unit: RTL

Parametrised multi-cycle load/store unit that replaces single-cycle RAM access in the MEM stage with a handshaked data-bus transaction. It accepts one request at a time from the MEM stage and stalls the pipeline while the request is outstanding. It checks alignment, drives byte-lane selects and write-data replication for either endianness, and sign- or zero-extends load data. It reports address errors, bus errors and timeouts as exception codes.

---
 rtl/mem_bus_unit.sv | 197 +++++++++++++++++++
 1 files changed

// File: rtl/mem_bus_unit.sv
// Load/store unit: one MEM-stage access at a time over a handshaked data bus, with alignment checks, lane steering and load extension.
// Latency: request accepted in T, bus_req_o in T+1, done_o one cycle after the ack/err/timeout cycle (T+2 minimum).
// Backpressure: stall_o holds the pipeline from acceptance until the response cycle; a flushed access drains on the bus silently.
module mem_bus_unit #(
    parameter int DATA_W     = 32,
    parameter int ADDR_W     = 32,
    parameter bit BIG_ENDIAN = 1'b1,
    parameter int TIMEOUT    = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_i,
    input  logic                  we_i,
    input  logic [1:0]            size_i,
    input  logic                  unsigned_i,
    input  logic [ADDR_W-1:0]     addr_i,
    input  logic [DATA_W-1:0]     wdata_i,
    input  logic                  flush_i,
    output logic                  stall_o,
    output logic                  done_o,
    output logic [DATA_W-1:0]     rdata_o,
    output logic [1:0]            exc_o,
    output logic                  bus_req_o,
    output logic                  bus_we_o,
    output logic [ADDR_W-1:0]     bus_addr_o,
    output logic [DATA_W/8-1:0]   bus_sel_o,
    output logic [DATA_W-1:0]     bus_wdata_o,
    input  logic                  bus_ack_i,
    input  logic                  bus_err_i,
    input  logic [DATA_W-1:0]     bus_rdata_i
);

    localparam int LANES = DATA_W / 8;
    localparam int OFS_W = $clog2(LANES);
    localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, BUSY, DRAIN, RESP} state_t;

    state_t              state_q;
    logic                bus_req_q;
    logic                bus_we_q;
    logic [ADDR_W-1:0]   bus_addr_q;
    logic [LANES-1:0]    bus_sel_q;
    logic [DATA_W-1:0]   bus_wdata_q;
    logic [CNT_W-1:0]    cnt_q;
    logic [1:0]          exc_q;
    logic [DATA_W-1:0]   rdata_q;
    logic [1:0]          size_q;
    logic                uns_q;
    logic [OFS_W-1:0]    pos_q;

    logic [OFS_W-1:0]    off;
    logic [OFS_W-1:0]    bytes_m1;
    logic [OFS_W-1:0]    pos;
    logic [LANES-1:0]    mask;
    logic [DATA_W-1:0]   wrep;
    logic                misal;
    logic [DATA_W-1:0]   shifted;
    logic [DATA_W-1:0]   ext;
    logic [CNT_W-1:0]    cnt_inc;
    logic                tmo;

    // Request decode: alignment, lane position, lane mask and replicated store data.
    always_comb begin
        off = addr_i[OFS_W-1:0];
        case (size_i)
            2'b00: begin
                bytes_m1 = '0;
                mask     = LANES'(1);
                wrep     = {LANES{wdata_i[7:0]}};
            end
            2'b01: begin
                bytes_m1 = OFS_W'(1);
                mask     = LANES'(3);
                wrep     = {(LANES/2){wdata_i[15:0]}};
            end
            2'b10: begin
                bytes_m1 = OFS_W'(3);
                mask     = LANES'(15);
                wrep     = {(LANES/4){wdata_i[31:0]}};
            end
            default: begin
                bytes_m1 = OFS_W'(7);
                mask     = '1;
                wrep     = wdata_i;
            end
        endcase
        misal = ((size_i == 2'b01) && addr_i[0])
              || ((size_i == 2'b10) && (|addr_i[1:0]))
              || ((size_i == 2'b11) && ((DATA_W == 32) || (|addr_i[2:0])));
        // Big-endian: lowest-addressed byte sits in the highest lane of the access.
        pos = BIG_ENDIAN ? (~off - bytes_m1) : off;
    end

    // Load result: shift the addressed lanes down, then sign/zero extend.
    always_comb begin
        shifted = bus_rdata_i >> {pos_q, 3'b000};
        case (size_q)
            2'b00:   ext = uns_q ? DATA_W'(shifted[7:0])  : DATA_W'($signed(shifted[7:0]));
            2'b01:   ext = uns_q ? DATA_W'(shifted[15:0]) : DATA_W'($signed(shifted[15:0]));
            2'b10:   ext = uns_q ? DATA_W'(shifted[31:0]) : DATA_W'($signed(shifted[31:0]));
            default: ext = shifted;
        endcase
        cnt_inc = cnt_q + 1'b1;
        tmo     = (TIMEOUT != 0) && (cnt_inc == CNT_W'(TIMEOUT));
    end

    // Access FSM with registered bus outputs and response state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            bus_req_q   <= 1'b0;
            bus_we_q    <= 1'b0;
            bus_addr_q  <= '0;
            bus_sel_q   <= '0;
            bus_wdata_q <= '0;
            cnt_q       <= '0;
            exc_q       <= 2'b00;
            rdata_q     <= '0;
            size_q      <= 2'b00;
            uns_q       <= 1'b0;
            pos_q       <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (req_i && !flush_i) begin
                        size_q <= size_i;
                        uns_q  <= unsigned_i;
                        pos_q  <= pos;
                        if (misal) begin
                            state_q <= RESP;
                            exc_q   <= we_i ? 2'b10 : 2'b01;
                        end else begin
                            state_q     <= BUSY;
                            exc_q       <= 2'b00;
                            bus_req_q   <= 1'b1;
                            bus_we_q    <= we_i;
                            bus_addr_q  <= {addr_i[ADDR_W-1:OFS_W], {OFS_W{1'b0}}};
                            bus_sel_q   <= mask << pos;
                            bus_wdata_q <= wrep;
                        end
                    end
                end
                BUSY: begin
                    if (bus_err_i || bus_ack_i || tmo) begin
                        state_q   <= RESP;
                        bus_req_q <= 1'b0;
                        bus_we_q  <= 1'b0;
                        cnt_q     <= '0;
                        // Error beats ack; no ack and no error means timeout.
                        exc_q     <= (bus_err_i || !bus_ack_i) ? 2'b11 : 2'b00;
                        if (bus_ack_i && !bus_err_i) begin
                            rdata_q <= bus_we_q ? '0 : ext;
                        end
                    end else if (flush_i) begin
                        // Bus transfer is in flight: keep the request up and let it finish unseen.
                        state_q <= DRAIN;
                        cnt_q   <= '0;
                    end else begin
                        cnt_q <= cnt_inc;
                    end
                end
                DRAIN: begin
                    if (bus_err_i || bus_ack_i || tmo) begin
                        state_q   <= IDLE;
                        bus_req_q <= 1'b0;
                        bus_we_q  <= 1'b0;
                        cnt_q     <= '0;
                    end else begin
                        cnt_q <= cnt_inc;
                    end
                end
                RESP: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // Pipeline-facing outputs; a flush in the response cycle suppresses the completion.
    always_comb begin
        stall_o = ((state_q == IDLE) && req_i && !flush_i) || (state_q == BUSY) || (state_q == DRAIN);
        done_o  = (state_q == RESP) && !flush_i;
        exc_o   = done_o ? exc_q : 2'b00;
    end

    assign rdata_o     = rdata_q;
    assign bus_req_o   = bus_req_q;
    assign bus_we_o    = bus_we_q;
    assign bus_addr_o  = bus_addr_q;
    assign bus_sel_o   = bus_sel_q;
    assign bus_wdata_o = bus_wdata_q;

endmodule
